// File: rtl/eth_rx_filter_if.sv
// Egress payload stream: registered byte, valid/ready handshake, last flag and EtherType.
interface eth_rx_filter_if;
  logic [7:0]  m_byte;
  logic        m_vld;
  logic        m_rdy;
  logic        m_last;
  logic [15:0] m_type;

  modport master (output m_byte, output m_vld, output m_last, output m_type, input m_rdy);
  modport slave  (input m_byte, input m_vld, input m_last, input m_type, output m_rdy);
endinterface

// File: rtl/eth_rx_filter.sv
// Ethernet receive filter: destination-address match, header strip, payload buffering
// with commit/rollback on frame end, and a descriptor-driven egress stream.
module eth_rx_filter #(
  parameter int unsigned P_DEPTH     = 2048,
  parameter logic [47:0] P_MAC_ADDR  = 48'h02_00_00_00_00_01,
  parameter int unsigned P_MIN_LEN   = 64,
  parameter int unsigned P_LEN_DEPTH = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [7:0]            sys_byte,
  input  logic                  sys_byte_vld,
  input  logic                  sys_data_vld,
  input  logic                  crc_vld,
  eth_rx_filter_if.master       m_if,
  output logic [15:0]           cnt_ok,
  output logic [15:0]           cnt_addr,
  output logic [15:0]           cnt_runt,
  output logic [15:0]           cnt_crc,
  output logic [15:0]           cnt_ovf
);
  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(P_LEN_DEPTH);
  localparam int unsigned QW = LW + 1;
  localparam int unsigned BW = 11;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DISCARD} state_t;
  typedef struct packed {
    logic [15:0]   etype;
    logic [BW-1:0] len;
  } desc_t;

  logic [7:0] buf_mem [P_DEPTH];
  desc_t      desc_mem [P_LEN_DEPTH];

  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d, rem_q, rem_d;
  logic          ucast_q, ucast_d, bcast_q, bcast_d, ovf_q, ovf_d, busy_q, busy_d;
  logic [15:0]   type_q, type_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QW-1:0] dwr_q, dwr_d, drd_q, drd_d, desc_fill_c;
  logic [15:0]   cnt_ok_q, cnt_ok_d, cnt_addr_q, cnt_addr_d, cnt_runt_q, cnt_runt_d;
  logic [15:0]   cnt_crc_q, cnt_crc_d, cnt_ovf_q, cnt_ovf_d;
  logic          m_vld_q, m_vld_d, m_last_q, m_last_d;
  logic [7:0]    m_byte_q, m_byte_d;
  logic [15:0]   m_type_q, m_type_d;
  logic          data_beat_c, term_c, buf_full_c, desc_full_c, desc_empty_c;
  logic          mem_we_c, push_c, load_c;
  logic [QW:0]   desc_used_c;
  logic [BW-1:0] bcnt_inc_c;
  desc_t         head_c, push_desc_c;

  function automatic logic [7:0] mac_byte(input logic [2:0] idx);
    logic [47:0] sh;
    sh = P_MAC_ADDR << {idx, 3'b000};
    return sh[47:40];
  endfunction

  assign data_beat_c  = sys_byte_vld & sys_data_vld;
  assign term_c       = sys_byte_vld & ~sys_data_vld;
  assign bcnt_inc_c   = (bcnt_q == '1) ? bcnt_q : bcnt_q + BW'(1);
  assign buf_full_c   = (wr_ptr_q - rd_ptr_q) == PW'(P_DEPTH);
  // A descriptor slot stays reserved until its frame's last byte leaves the output register.
  assign desc_fill_c  = dwr_q - drd_q;
  assign desc_used_c  = {1'b0, desc_fill_c} + (QW+1)'(busy_q);
  assign desc_full_c  = desc_used_c >= (QW+1)'(P_LEN_DEPTH);
  assign desc_empty_c = (dwr_q == drd_q);
  assign head_c       = desc_mem[drd_q[LW-1:0]];
  assign push_desc_c  = '{etype: type_q, len: bcnt_q - BW'(18)};

  // Ingress FSM: header parse, payload write, end-of-frame verdict.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    ucast_d      = ucast_q;
    bcast_d      = bcast_q;
    type_d       = type_q;
    ovf_d        = ovf_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    cnt_ok_d     = cnt_ok_q;
    cnt_addr_d   = cnt_addr_q;
    cnt_runt_d   = cnt_runt_q;
    cnt_crc_d    = cnt_crc_q;
    cnt_ovf_d    = cnt_ovf_q;
    mem_we_c     = 1'b0;
    push_c       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_beat_c) begin
          state_d = S_HDR;
          bcnt_d  = BW'(1);
          ucast_d = (sys_byte == mac_byte(3'd0));
          bcast_d = (sys_byte == 8'hFF);
          ovf_d   = 1'b0;
        end
      end
      S_HDR: begin
        if (data_beat_c) begin
          bcnt_d = bcnt_inc_c;
          if (bcnt_q < BW'(6)) begin
            ucast_d = ucast_q & (sys_byte == mac_byte(bcnt_q[2:0]));
            bcast_d = bcast_q & (sys_byte == 8'hFF);
          end
          if (bcnt_q == BW'(12)) type_d[15:8] = sys_byte;
          if (bcnt_q == BW'(13)) begin
            type_d[7:0] = sys_byte;
            if (ucast_q | bcast_q) begin
              state_d = S_PAYLOAD;
            end else begin
              state_d    = S_DISCARD;
              cnt_addr_d = cnt_addr_q + 16'd1;
            end
          end
        end else if (term_c) begin
          state_d    = S_IDLE;
          cnt_runt_d = cnt_runt_q + 16'd1;
        end
      end
      S_PAYLOAD: begin
        if (data_beat_c) begin
          bcnt_d = bcnt_inc_c;
          if (buf_full_c) begin
            ovf_d = 1'b1;
          end else begin
            mem_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
        end else if (term_c) begin
          state_d  = S_IDLE;
          wr_ptr_d = commit_ptr_q;
          if (ovf_q || desc_full_c) begin
            cnt_ovf_d = cnt_ovf_q + 16'd1;
          end else if (bcnt_q < BW'(P_MIN_LEN)) begin
            cnt_runt_d = cnt_runt_q + 16'd1;
          end else if (!crc_vld) begin
            cnt_crc_d = cnt_crc_q + 16'd1;
          end else begin
            // FCS bytes are reclaimed so the next frame packs right behind this payload.
            push_c       = 1'b1;
            commit_ptr_d = wr_ptr_q - PW'(4);
            wr_ptr_d     = wr_ptr_q - PW'(4);
            cnt_ok_d     = cnt_ok_q + 16'd1;
          end
        end
      end
      S_DISCARD: begin
        if (term_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dwr_d = push_c ? dwr_q + QW'(1) : dwr_q;

  // Egress: refill the output register whenever it is empty or being consumed.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    drd_d    = drd_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    m_vld_d  = m_vld_q;
    m_last_d = m_last_q;
    m_byte_d = m_byte_q;
    m_type_d = m_type_q;
    load_c   = !m_vld_q || m_if.m_rdy;
    if (m_vld_q && m_if.m_rdy && m_last_q) busy_d = 1'b0;
    if (load_c) begin
      if (rem_q != '0) begin
        m_vld_d  = 1'b1;
        m_byte_d = buf_mem[rd_ptr_q[AW-1:0]];
        m_last_d = (rem_q == BW'(1));
        rem_d    = rem_q - BW'(1);
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else if (!desc_empty_c) begin
        busy_d   = 1'b1;
        drd_d    = drd_q + QW'(1);
        m_vld_d  = 1'b1;
        m_byte_d = buf_mem[rd_ptr_q[AW-1:0]];
        m_last_d = (head_c.len == BW'(1));
        m_type_d = head_c.etype;
        rem_d    = head_c.len - BW'(1);
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        m_vld_d  = 1'b0;
        m_last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      ucast_q      <= 1'b0;
      bcast_q      <= 1'b0;
      type_q       <= '0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      dwr_q        <= '0;
      drd_q        <= '0;
      rem_q        <= '0;
      busy_q       <= 1'b0;
      cnt_ok_q     <= '0;
      cnt_addr_q   <= '0;
      cnt_runt_q   <= '0;
      cnt_crc_q    <= '0;
      cnt_ovf_q    <= '0;
      m_vld_q      <= 1'b0;
      m_last_q     <= 1'b0;
      m_byte_q     <= '0;
      m_type_q     <= '0;
      for (int i = 0; i < int'(P_LEN_DEPTH); i++) desc_mem[i] <= '0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      ucast_q      <= ucast_d;
      bcast_q      <= bcast_d;
      type_q       <= type_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dwr_q        <= dwr_d;
      drd_q        <= drd_d;
      rem_q        <= rem_d;
      busy_q       <= busy_d;
      cnt_ok_q     <= cnt_ok_d;
      cnt_addr_q   <= cnt_addr_d;
      cnt_runt_q   <= cnt_runt_d;
      cnt_crc_q    <= cnt_crc_d;
      cnt_ovf_q    <= cnt_ovf_d;
      m_vld_q      <= m_vld_d;
      m_last_q     <= m_last_d;
      m_byte_q     <= m_byte_d;
      m_type_q     <= m_type_d;
      if (push_c) desc_mem[dwr_q[LW-1:0]] <= push_desc_c;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (mem_we_c) buf_mem[wr_ptr_q[AW-1:0]] <= sys_byte;
  end

  assign m_if.m_vld  = m_vld_q;
  assign m_if.m_last = m_last_q;
  assign m_if.m_byte = m_byte_q;
  assign m_if.m_type = m_type_q;
  assign cnt_ok      = cnt_ok_q;
  assign cnt_addr    = cnt_addr_q;
  assign cnt_runt    = cnt_runt_q;
  assign cnt_crc     = cnt_crc_q;
  assign cnt_ovf     = cnt_ovf_q;
endmodule
